// File: rtl/ps2_tx_pkg.sv
// PS/2 transmitter shared definitions: frame constants, FSM state encodings
// and the odd-parity helper used by the serialiser.
package ps2_tx_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO, DEPTH x 8, async active-low reset.
// Ports: clk, rst_n, push/din, pop/dout, full, empty, count.
module ps2_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/ps2_tx.sv
// PS/2-style serial transmitter: FIFO-buffered bytes sent as start, 8 data, odd parity, stop.
// Ports: clk, rst_n, tx_data/tx_valid/tx_ready, data_out (idle high), busy, frame_done.
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW      = $clog2(CLKS_PER_BIT + 1);
  localparam int GAP_CYC = IDLE_BITS * CLKS_PER_BIT;
  localparam int GW      = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic [2:0]    state;
  logic [7:0]    sh;
  logic          par;
  logic [2:0]    idx;
  logic [CW-1:0] cyc;
  logic [GW-1:0] gcnt;
  logic          rdy_q;

  logic [7:0]            f_dout;
  logic                  f_full;
  logic                  f_empty;
  logic [$clog2(DEPTH):0] f_count;

  logic       push;
  logic       pop;
  logic       bit_end;
  logic [7:0] sh_nxt;

  // rdy_q keeps tx_ready low through reset and opens it one edge after release
  assign tx_ready = rdy_q && !f_full;
  assign push     = tx_valid && tx_ready;
  assign pop      = (state == S_IDLE) && !f_empty;
  assign busy     = (state != S_IDLE) || (f_count != '0);
  assign bit_end  = cyc == CYC_LAST;
  assign sh_nxt   = (MSB_FIRST != 0) ? {sh[6:0], 1'b0}
                                     : {1'b0, sh[7:1]};

  function automatic logic head(input logic [7:0] b);
    return (MSB_FIRST != 0) ? b[7] : b[0];
  endfunction

  ps2_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sh         <= '0;
      par        <= 1'b0;
      idx        <= '0;
      cyc        <= '0;
      gcnt       <= '0;
      data_out   <= 1'b1;
      frame_done <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      frame_done <= 1'b0;
      unique case (1'b1)
        state == S_IDLE: begin
          data_out <= 1'b1;
          cyc      <= '0;
          if (!f_empty) begin
            sh       <= f_dout;
            par      <= odd_par(f_dout);
            state    <= S_START;
            data_out <= START_BIT;
          end
        end
        state == S_START: begin
          if (bit_end) begin
            cyc      <= '0;
            idx      <= '0;
            state    <= S_DATA;
            data_out <= head(sh);
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        state == S_DATA: begin
          if (bit_end) begin
            cyc <= '0;
            if (idx == IDX_LAST) begin
              state    <= S_PARITY;
              data_out <= par;
            end else begin
              idx      <= idx + 1'b1;
              sh       <= sh_nxt;
              data_out <= head(sh_nxt);
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        state == S_PARITY: begin
          if (bit_end) begin
            cyc      <= '0;
            state    <= S_STOP;
            data_out <= STOP_BIT;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        state == S_STOP: begin
          if (bit_end) begin
            cyc        <= '0;
            gcnt       <= '0;
            frame_done <= 1'b1;
            data_out   <= 1'b1;
            state      <= (IDLE_BITS > 0) ? S_GAP : S_IDLE;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        state == S_GAP: begin
          data_out <= 1'b1;
          if (gcnt == GAP_LAST) state <= S_IDLE;
          else                  gcnt  <= gcnt + 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          data_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx: two instances (default and slow/LSB-first)
// with accepted bytes queued and frames decoded by per-instance monitors.
module tb_ps2_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       r0, r1;
  logic       o0, o1;
  logic       b0, b1;
  logic       f0, f1;

  int errors = 0;
  int checks = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         have_prev[2];
  bit         b2b[2];

  ps2_tx u0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (d0),
    .tx_valid   (v0),
    .tx_ready   (r0),
    .data_out   (o0),
    .busy       (b0),
    .frame_done (f0)
  );

  ps2_tx #(
    .DEPTH        (4),
    .CLKS_PER_BIT (4),
    .IDLE_BITS    (2),
    .MSB_FIRST    (0)
  ) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (d1),
    .tx_valid   (v1),
    .tx_ready   (r1),
    .data_out   (o1),
    .busy       (b1),
    .frame_done (f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic line(input int i);
    return (i == 0) ? o0 : o1;
  endfunction
  function automatic logic fdn(input int i);
    return (i == 0) ? f0 : f1;
  endfunction
  function automatic logic rdy(input int i);
    return (i == 0) ? r0 : r1;
  endfunction
  function automatic logic bsy(input int i);
    return (i == 0) ? b0 : b1;
  endfunction
  function automatic int cpb(input int i);
    return (i == 0) ? 1 : 4;
  endfunction
  function automatic int idl(input int i);
    return (i == 0) ? 1 : 2;
  endfunction
  function automatic bit msbf(input int i);
    return i == 0;
  endfunction
  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  function automatic logic [7:0] qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Line image of one frame, indexed by bit position in time order
  function automatic logic [10:0] frame_of(input logic [7:0] b,
                                           input bit msb);
    logic [10:0] r;
    r[0] = 1'b0;
    for (int k = 0; k < 8; k++) r[1+k] = msb ? b[7-k] : b[k];
    r[9]  = ($countones(b) % 2) == 0;
    r[10] = 1'b1;
    return r;
  endfunction

  task automatic drive(input int i, input logic v, input logic [7:0] d);
    if (i == 0) begin v0 = v; d0 = d; end
    else        begin v1 = v; d1 = d; end
  endtask

  task automatic send(input int i, input logic [7:0] b, output int rej);
    rej = 0;
    @(negedge clk);
    drive(i, 1'b1, b);
    while (!rdy(i) && rej < 300) begin
      @(negedge clk);
      rej++;
    end
    chk($sformatf("ready timeout inst%0d", i), rdy(i), 1);
    if (rdy(i)) begin
      @(posedge clk);
      if (i == 0) q0.push_back(b);
      else        q1.push_back(b);
      #1;
    end
    drive(i, 1'b0, 8'h00);
  endtask

  task automatic mon(input int i);
    int          n = -1;
    int          hr = 0;
    bit          fd_exp = 0;
    logic [10:0] fr = '1;
    logic [7:0]  eb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = -1; hr = 0; fd_exp = 0; have_prev[i] = 0;
        continue;
      end
      chk($sformatf("frame_done inst%0d", i), fdn(i), fd_exp);
      fd_exp = 0;
      if (n < 0) begin
        if (line(i) == 1'b0) begin
          chk($sformatf("frame expected inst%0d", i), qsize(i) != 0, 1);
          eb = (qsize(i) != 0) ? qpop(i) : 8'h00;
          fr = frame_of(eb, msbf(i));
          if (have_prev[i]) begin
            if (b2b[i])
              chk($sformatf("gap inst%0d", i), hr, idl(i) * cpb(i) + 1);
            else
              chk($sformatf("min gap inst%0d", i),
                  hr >= idl(i) * cpb(i) + 1, 1);
          end
          n = 0;
        end else begin
          hr++;
        end
      end
      if (n >= 0) begin
        chk($sformatf("inst%0d byte %02h bit %0d", i, eb, n / cpb(i)),
            line(i), fr[n / cpb(i)]);
        n++;
        if (n == 11 * cpb(i)) begin
          n = -1; hr = 0; fd_exp = 1; have_prev[i] = 1;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || b0 || b1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", t < 5000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t, limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat[6];
    int         rej[6];
    int         r;
    int         t;

    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst data_out0", o0, 1);
    chk("rst tx_ready0", r0, 0);
    chk("rst busy0", b0, 0);
    chk("rst frame_done0", f0, 0);
    chk("rst data_out1", o1, 1);
    chk("rst tx_ready1", r1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready after release", r0, 1);

    // 0xB2: start latency then serial pattern checked by monitor
    send(0, 8'hB2, r);
    chk("latency pre", o0, 1);
    @(posedge clk); #1;
    chk("latency start", o0, 0);
    drain();

    // parity cases and LSB-first ordering
    send(0, 8'h00, r);
    send(0, 8'h01, r);
    send(0, 8'hFF, r);
    send(1, 8'h01, r);
    drain();

    // FIFO full while valid held for six cycles
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    have_prev[0] = 0;
    b2b[0] = 1;
    for (int j = 0; j < 6; j++) send(0, pat[j], rej[j]);
    for (int j = 0; j < 5; j++)
      chk($sformatf("accept %0d", j), rej[j], 0);
    chk("F rejected edges", rej[5], 10);
    drain();
    b2b[0] = 0;

    // slow instance, two back-to-back frames
    have_prev[1] = 0;
    b2b[1] = 1;
    send(1, 8'hA5, r);
    send(1, 8'hA5, r);
    drain();
    b2b[1] = 0;

    // reset in the middle of data bit 3
    send(0, 8'hC3, r);
    t = 0;
    while (o0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("start seen", o0, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst data_out", o0, 1);
    chk("mid rst busy", b0, 0);
    chk("mid rst frame_done", f0, 0);
    chk("mid rst tx_ready", r0, 0);
    q0.delete();
    repeat (2) @(negedge clk);
    chk("mid rst hold frame_done", f0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst ready", r0, 1);
    chk("post rst fifo empty", b0, 0);
    @(posedge clk); #1;
    chk("post rst still idle", o0, 1);
    send(0, 8'h55, r);
    drain();

    // randomized traffic on both instances
    fork
      begin
        for (int k = 0; k < 15; k++) begin
          int rj;
          send(0, 8'($urandom), rj);
          repeat ($urandom_range(0, 15)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 10; k++) begin
          int rj;
          send(1, 8'($urandom), rj);
          repeat ($urandom_range(0, 40)) @(negedge clk);
        end
      end
    join
    drain();
    chk("queue0 empty", q0.size(), 0);
    chk("queue1 empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
